// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply host sequencer.
package matmul_pkg;

  // Host sequencer states, in the order a normal job walks through them.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadD = 3'd1,
    StLoadI = 3'd2,
    StRun   = 3'd3,
    StDrain = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [1:0] CORE_OFF = 2'b00;
  localparam logic [1:0] CORE_RUN = 2'b01;

  // Low n bits set; callers truncate to their lane count.
  function automatic logic [31:0] core_mask(input int unsigned n);
    if (n >= 32) begin
      return '1;
    end
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/matmul_drain_buf.sv
// One-entry registered result slot plus the DM read-issue logic feeding it.
// A read is launched only when the slot is empty or draining this cycle. While
// the slot is stalled the pending address is presented again, so the
// synchronous memory keeps returning the same word until it can be taken.
module matmul_drain_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [ADDR_W:0]   i_rlen,
  input  logic              i_out_ready,
  input  logic [DATA_W-1:0] i_dm_rdata,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_last
);

  logic [ADDR_W:0]   r_rd_cnt;
  logic              r_pend;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  logic              w_free;
  logic              w_more;
  logic              w_issue;
  logic              w_load;
  logic [ADDR_W-1:0] w_prev;

  // Read-issue and slot-load decisions for the current cycle.
  always_comb begin
    w_free    = !r_valid || i_out_ready;
    w_more    = r_rd_cnt < i_rlen;
    w_issue   = i_en && w_more && w_free;
    w_load    = i_en && r_pend && w_free;
    w_prev    = r_rd_cnt[ADDR_W-1:0] - ADDR_W'(1);
    o_dm_addr = w_issue ? r_rd_cnt[ADDR_W-1:0] : w_prev;
    o_last    = i_en && r_valid && i_out_ready && !w_more && !r_pend;
  end

  // Slot and read-pointer state; everything clears whenever draining is off.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_rd_cnt <= '0;
      r_pend   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
      end
      r_pend <= w_issue || (r_pend && !w_load);
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= i_dm_rdata;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

endmodule

// File: rtl/matmul_host_ctrl.sv
// Host-side sequencer: load DM, load IM, run the cores, drain the result.
// Optional RUN watchdog enabled by defining MATMUL_TIMEOUT_EN.
module matmul_host_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned INSTR_W        = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [ADDR_W:0]                i_data_len,
  input  logic [ADDR_W:0]                i_instr_len,
  input  logic [$clog2(NUM_CORES+1)-1:0] i_active_cores,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [DATA_W-1:0]              i_in_data,
  output logic                           o_dm_wr_en,
  output logic [ADDR_W-1:0]              o_dm_addr,
  output logic [DATA_W-1:0]              o_dm_wdata,
  input  logic [DATA_W-1:0]              i_dm_rdata,
  output logic                           o_im_wr_en,
  output logic [ADDR_W-1:0]              o_im_addr,
  output logic [INSTR_W-1:0]             o_im_wdata,
  output logic [2*NUM_CORES-1:0]         o_core_status,
  input  logic [NUM_CORES-1:0]           i_core_end,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [DATA_W-1:0]              o_out_data,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err
);

  localparam int unsigned AC_W = $clog2(NUM_CORES+1);
  localparam int unsigned CW   = ADDR_W + 1;
  localparam int unsigned PW   = 3 * DATA_W;
  localparam logic [PW-1:0] RMAX = PW'(1) << ADDR_W;

  state_e             r_state;
  state_e             w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_dl;
  logic [CW-1:0]      r_il;
  logic [AC_W-1:0]    r_ac;
  logic [DATA_W-1:0]  r_ci;
  logic [DATA_W-1:0]  r_cj;
  logic [DATA_W-1:0]  r_ck;
  logic               r_err;

  logic               w_start_ok;
  logic               w_hs;
  logic [NUM_CORES-1:0] w_mask;
  logic               w_all_end;
  logic [PW-1:0]      w_prod;
  logic [CW-1:0]      w_rlen;
  logic               w_tmo;
  logic [ADDR_W-1:0]  w_drain_addr;
  logic               w_drain_last;

  assign w_start_ok = (i_active_cores != '0) && (i_active_cores <= AC_W'(NUM_CORES)) &&
                      (i_data_len >= CW'(3));
  assign w_hs       = o_in_ready && i_in_valid;
  assign w_mask     = NUM_CORES'(core_mask(32'(r_ac)));
  assign w_all_end  = (i_core_end & w_mask) == w_mask;

  // Result length at full precision, saturated to the DM depth.
  assign w_prod = PW'(r_ci) * PW'(r_cj) * PW'(r_ck);
  assign w_rlen = (w_prod > RMAX) ? CW'(RMAX) : w_prod[CW-1:0];

`ifdef MATMUL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // RUN-cycle watchdog; held at zero outside RUN so each entry starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != StRun)) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_tmo = (r_state == StRun) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the write/status outputs.
  always_comb begin
    w_state_next  = r_state;
    o_in_ready    = 1'b0;
    o_dm_wr_en    = 1'b0;
    o_dm_addr     = '0;
    o_dm_wdata    = '0;
    o_im_wr_en    = 1'b0;
    o_im_addr     = '0;
    o_im_wdata    = '0;
    o_core_status = '0;
    unique case (r_state)
      StIdle: begin
        if (i_start && w_start_ok) w_state_next = StLoadD;
      end
      StLoadD: begin
        o_in_ready = 1'b1;
        o_dm_wr_en = i_in_valid;
        o_dm_addr  = r_cnt[ADDR_W-1:0];
        o_dm_wdata = i_in_data;
        if (w_hs && (r_cnt == r_dl - CW'(1))) begin
          w_state_next = (r_il == '0) ? StRun : StLoadI;
        end
      end
      StLoadI: begin
        o_in_ready = 1'b1;
        o_im_wr_en = i_in_valid;
        o_im_addr  = r_cnt[ADDR_W-1:0];
        o_im_wdata = i_in_data[INSTR_W-1:0];
        if (w_hs && (r_cnt == r_il - CW'(1))) w_state_next = StRun;
      end
      StRun: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          o_core_status[2*i +: 2] = w_mask[i] ? CORE_RUN : CORE_OFF;
        end
        // Completion wins over a watchdog expiry in the same cycle.
        if (w_all_end) begin
          w_state_next = (w_rlen == '0) ? StDone : StDrain;
        end else if (w_tmo) begin
          w_state_next = StDone;
        end
      end
      StDrain: begin
        o_dm_addr = w_drain_addr;
        if (w_drain_last) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Job parameters, load counter, captured dimensions and the sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_dl  <= '0;
      r_il  <= '0;
      r_ac  <= '0;
      r_ci  <= '0;
      r_cj  <= '0;
      r_ck  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == StIdle && i_start) begin
        if (w_start_ok) begin
          r_dl  <= i_data_len;
          r_il  <= i_instr_len;
          r_ac  <= i_active_cores;
          r_cnt <= '0;
          r_err <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == StLoadD && w_hs) begin
        if (r_cnt == CW'(0)) r_ci <= i_in_data;
        if (r_cnt == CW'(1)) r_cj <= i_in_data;
        if (r_cnt == CW'(2)) r_ck <= i_in_data;
        r_cnt <= (r_cnt == r_dl - CW'(1)) ? '0 : r_cnt + CW'(1);
      end
      if (r_state == StLoadI && w_hs) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == StRun && !w_all_end && w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  matmul_drain_buf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_drain_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (r_state == StDrain),
    .i_rlen      (w_rlen),
    .i_out_ready (i_out_ready),
    .i_dm_rdata  (i_dm_rdata),
    .o_dm_addr   (w_drain_addr),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_last      (w_drain_last)
  );

  assign o_busy = (r_state != StIdle);
  assign o_done = (r_state == StDone);
  assign o_err  = r_err;

endmodule
